// File: rtl/scroll_controller.sv
// Per-layer scroll offset sequencer for a VGA compositor.
// Offsets step once per frame and publish atomically at commit.
module scroll_controller #(
    parameter int NUM_LAYERS = 2,
    parameter int OFFSET_W   = 12,
    parameter int MIN_OFF    = -600,
    parameter int MAX_OFF    = 600,
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vsync,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [LW-1:0]                  cmd_layer,
    input  logic [2:0]                     cmd_field,
    input  logic signed [OFFSET_W-1:0]     cmd_data,
    output logic [NUM_LAYERS*OFFSET_W-1:0] hoffset,
    output logic [NUM_LAYERS*OFFSET_W-1:0] voffset,
    output logic                           frame_done,
    output logic [15:0]                    frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        COMMIT
    } state_t;

    localparam logic signed [OFFSET_W:0]   MIN_S = (OFFSET_W+1)'(MIN_OFF);
    localparam logic signed [OFFSET_W:0]   MAX_S = (OFFSET_W+1)'(MAX_OFF);
    localparam logic signed [OFFSET_W-1:0] MIN_W = OFFSET_W'(MIN_OFF);
    localparam logic signed [OFFSET_W-1:0] MAX_W = OFFSET_W'(MAX_OFF);

    state_t state;
    state_t state_next;
    logic [LW-1:0] idx;
    logic vsync_q;
    logic tick;
    logic accept;
    logic layer_ok;
    logic last_layer;

    logic signed [OFFSET_W-1:0] vel_h  [NUM_LAYERS];
    logic signed [OFFSET_W-1:0] vel_v  [NUM_LAYERS];
    logic signed [OFFSET_W-1:0] pos_h  [NUM_LAYERS];
    logic signed [OFFSET_W-1:0] pos_v  [NUM_LAYERS];
    logic                       ld_h   [NUM_LAYERS];
    logic                       ld_v   [NUM_LAYERS];
    logic                       en     [NUM_LAYERS];
    logic signed [OFFSET_W-1:0] work_h [NUM_LAYERS];
    logic signed [OFFSET_W-1:0] work_v [NUM_LAYERS];
    logic signed [OFFSET_W-1:0] next_h;
    logic signed [OFFSET_W-1:0] next_v;

    // Loads bypass the wrap; only stepped values are folded back into range.
    function automatic logic signed [OFFSET_W-1:0] step_off(
        input logic signed [OFFSET_W-1:0] off,
        input logic signed [OFFSET_W-1:0] vel,
        input logic signed [OFFSET_W-1:0] pos,
        input logic                       ena,
        input logic                       ld
    );
        logic signed [OFFSET_W:0] sum;
        sum = {off[OFFSET_W-1], off} + {vel[OFFSET_W-1], vel};
        if (ld)         return pos;
        if (!ena)       return off;
        if (sum < MIN_S) return MAX_W;
        if (sum > MAX_S) return MIN_W;
        return sum[OFFSET_W-1:0];
    endfunction

    assign tick       = vsync_q & ~vsync;
    assign cmd_ready  = (state == IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign layer_ok   = ({1'b0, cmd_layer} < (LW+1)'(NUM_LAYERS));
    assign last_layer = (idx == LW'(NUM_LAYERS - 1));

    // Next-state logic: one UPDATE cycle per layer, then a single COMMIT.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (tick) state_next = UPDATE;
            UPDATE:  if (last_layer) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Step results for the layer currently being sequenced.
    always_comb begin
        next_h = step_off(work_h[idx], vel_h[idx], pos_h[idx], en[idx], ld_h[idx]);
        next_v = step_off(work_v[idx], vel_v[idx], pos_v[idx], en[idx], ld_v[idx]);
    end

    // State register, layer index and vsync edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            vsync_q <= 1'b1;
        end else begin
            state   <= state_next;
            vsync_q <= vsync;
            if (state == UPDATE) idx <= idx + 1'b1;
            else                 idx <= '0;
        end
    end

    // Shadow registers take commands in IDLE; working regs step in UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                vel_h[i]  <= '0;
                vel_v[i]  <= '0;
                pos_h[i]  <= '0;
                pos_v[i]  <= '0;
                ld_h[i]   <= 1'b0;
                ld_v[i]   <= 1'b0;
                en[i]     <= 1'b0;
                work_h[i] <= '0;
                work_v[i] <= '0;
            end
        end else begin
            if (accept && layer_ok) begin
                case (cmd_field)
                    3'd0: vel_h[cmd_layer] <= cmd_data;
                    3'd1: vel_v[cmd_layer] <= cmd_data;
                    3'd2: begin
                        pos_h[cmd_layer] <= cmd_data;
                        ld_h[cmd_layer]  <= 1'b1;
                    end
                    3'd3: begin
                        pos_v[cmd_layer] <= cmd_data;
                        ld_v[cmd_layer]  <= 1'b1;
                    end
                    3'd4: en[cmd_layer] <= cmd_data[0];
                    default: ;
                endcase
            end
            if (state == UPDATE) begin
                work_h[idx] <= next_h;
                work_v[idx] <= next_v;
                ld_h[idx]   <= 1'b0;
                ld_v[idx]   <= 1'b0;
            end
        end
    end

    // Publish every layer at once when COMMIT ends, with a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hoffset     <= '0;
            voffset     <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= (state == COMMIT);
            if (state == COMMIT) begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    hoffset[i*OFFSET_W +: OFFSET_W] <= work_h[i];
                    voffset[i*OFFSET_W +: OFFSET_W] <= work_v[i];
                end
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_scroll_controller.sv
// Randomized bench for scroll_controller against a frame-level model.
// Directed scenarios cover stepping, wrap, handshake and resets.
module tb_scroll_controller;

    localparam int N  = 2;
    localparam int W  = 12;
    localparam int F_HVEL = 0;
    localparam int F_VVEL = 1;
    localparam int F_HPOS = 2;
    localparam int F_VPOS = 3;
    localparam int F_EN   = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           vsync;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [0:0]     cmd_layer;
    logic [2:0]     cmd_field;
    logic [W-1:0]   cmd_data;
    logic [N*W-1:0] hoffset;
    logic [N*W-1:0] voffset;
    logic           frame_done;
    logic [15:0]    frame_count;

    int n_chk  = 0;
    int n_pass = 0;

    int m_vh [N];
    int m_vv [N];
    int m_ph [N];
    int m_pv [N];
    int m_oh [N];
    int m_ov [N];
    bit m_lh [N];
    bit m_lv [N];
    bit m_en [N];
    int m_fc;

    scroll_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_layer   (cmd_layer),
        .cmd_field   (cmd_field),
        .cmd_data    (cmd_data),
        .hoffset     (hoffset),
        .voffset     (voffset),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int got_h(input int i);
        logic [W-1:0] s;
        s = hoffset[i*W +: W];
        return int'($signed(s));
    endfunction

    function automatic int got_v(input int i);
        logic [W-1:0] s;
        s = voffset[i*W +: W];
        return int'($signed(s));
    endfunction

    function automatic int sx(input int d);
        logic [W-1:0] s;
        s = W'(d);
        return int'($signed(s));
    endfunction

    function automatic int wrap(input int v);
        if (v < -600) return 600;
        if (v > 600)  return -600;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vh[i] = 0; m_vv[i] = 0; m_ph[i] = 0; m_pv[i] = 0;
            m_oh[i] = 0; m_ov[i] = 0;
            m_lh[i] = 0; m_lv[i] = 0; m_en[i] = 0;
        end
        m_fc = 0;
    endtask

    task automatic model_cmd(input int l, input int f, input int d);
        case (f)
            F_HVEL: m_vh[l] = sx(d);
            F_VVEL: m_vv[l] = sx(d);
            F_HPOS: begin m_ph[l] = sx(d); m_lh[l] = 1; end
            F_VPOS: begin m_pv[l] = sx(d); m_lv[l] = 1; end
            F_EN:   m_en[l] = d[0];
            default: ;
        endcase
    endtask

    task automatic model_tick();
        for (int i = 0; i < N; i++) begin
            if (m_lh[i]) begin m_oh[i] = m_ph[i]; m_lh[i] = 0; end
            else if (m_en[i]) m_oh[i] = wrap(m_oh[i] + m_vh[i]);
            if (m_lv[i]) begin m_ov[i] = m_pv[i]; m_lv[i] = 0; end
            else if (m_en[i]) m_ov[i] = wrap(m_ov[i] + m_vv[i]);
        end
        m_fc = (m_fc + 1) % 65536;
    endtask

    task automatic check_pub(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_h"}, got_h(i), m_oh[i]);
            check({tag, "_v"}, got_v(i), m_ov[i]);
        end
        check({tag, "_fc"}, frame_count, m_fc);
    endtask

    task automatic drive_cmd(input int l, input int f, input int d);
        cmd_valid = 1'b1;
        cmd_layer = 1'(l);
        cmd_field = 3'(f);
        cmd_data  = W'(d);
    endtask

    task automatic send(input int l, input int f, input int d);
        int k = 0;
        @(negedge clk);
        drive_cmd(l, f, d);
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            model_cmd(l, f, d);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic tick_frame(input bit co, input int l, input int f, input int d,
                              input bit glitch);
        logic [N*W-1:0] prev_h;
        logic [N*W-1:0] prev_v;
        int k = 0;
        prev_h = hoffset;
        prev_v = voffset;
        @(negedge clk);
        vsync = 1'b0;
        check("ready_tick", cmd_ready, 1);
        if (co) begin
            drive_cmd(l, f, d);
            model_cmd(l, f, d);
        end
        model_tick();
        @(negedge clk);
        vsync     = 1'b1;
        cmd_valid = 1'b0;
        check("ready_upd", cmd_ready, 0);
        while (!frame_done && k < 20) begin
            check("no_partial_h", hoffset, prev_h);
            check("no_partial_v", voffset, prev_v);
            @(negedge clk);
            k++;
            if (glitch && k == 1) vsync = 1'b0;
            if (k == 2) vsync = 1'b1;
        end
        check("latency", k, N + 1);
        check("frame_done", frame_done, 1);
        check_pub("pub");
        @(negedge clk);
        check("done_pulse", frame_done, 0);
    endtask

    task automatic reset_mid(input int at);
        bit seen = 0;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        repeat (at - 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_h", hoffset, 0);
        check("rst_v", voffset, 0);
        check("rst_fc", frame_count, 0);
        check("rst_fd", frame_done, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        repeat (4) begin
            if (frame_done) seen = 1;
            @(negedge clk);
        end
        check("rst_no_done", seen, 0);
    endtask

    initial begin
        int nc;
        rst_n     = 1'b0;
        vsync     = 1'b1;
        cmd_valid = 1'b0;
        cmd_layer = '0;
        cmd_field = '0;
        cmd_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_h", hoffset, 0);
        check("init_fc", frame_count, 0);
        check("init_fd", frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_ready", cmd_ready, 1);

        // step
        send(1, F_HPOS, 600);
        send(1, F_HVEL, -1);
        send(1, F_EN, 1);
        for (int k = 0; k < 3; k++) begin
            tick_frame(0, 0, 0, 0, 0);
            check("step_h1", got_h(1), 600 - k);
            check("step_h0", got_h(0), 0);
            check("step_fc", frame_count, k + 1);
        end

        // wrap
        send(0, F_HPOS, -600);
        send(0, F_HVEL, -1);
        send(0, F_VPOS, 598);
        send(0, F_VVEL, 5);
        send(0, F_EN, 1);
        tick_frame(0, 0, 0, 0, 0);
        check("wrap_h0a", got_h(0), -600);
        check("wrap_v0a", got_v(0), 598);
        tick_frame(0, 0, 0, 0, 1);
        check("wrap_h0b", got_h(0), 600);
        check("wrap_v0b", got_v(0), -600);

        // handshake
        @(negedge clk);
        vsync = 1'b0;
        check("hs_ready_T", cmd_ready, 1);
        model_tick();
        @(negedge clk);
        vsync = 1'b1;
        drive_cmd(0, F_HVEL, 3);
        for (int k = 1; k <= N + 1; k++) begin
            check("hs_ready_busy", cmd_ready, 0);
            @(negedge clk);
        end
        check("hs_ready_acc", cmd_ready, 1);
        check("hs_done", frame_done, 1);
        check_pub("hs_pub");
        model_cmd(0, F_HVEL, 3);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hs_done_end", frame_done, 0);
        tick_frame(0, 0, 0, 0, 0);

        // coincidence
        tick_frame(1, 0, F_HPOS, 100, 0);
        check("coin_h0", got_h(0), 100);

        // reset during COMMIT
        reset_mid(N + 1);
        tick_frame(0, 0, 0, 0, 0);

        // reset during UPDATE
        send(0, F_HPOS, 77);
        send(0, F_EN, 1);
        send(0, F_HVEL, 9);
        reset_mid(1);
        tick_frame(0, 0, 0, 0, 0);
        check("clr_h0", got_h(0), 0);
        check("clr_fc", frame_count, 1);

        // random
        for (int fr = 0; fr < 40; fr++) begin
            nc = $urandom_range(0, 5);
            for (int c = 0; c < nc; c++) begin
                int f;
                int d;
                f = $urandom_range(0, 7);
                if (f < 2 && $urandom_range(0, 3) != 0)
                    d = $urandom_range(0, 80) - 40;
                else
                    d = $urandom_range(0, 4095);
                send($urandom_range(0, 1), f, d);
            end
            tick_frame($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 4095),
                       $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scroll_controller.md
SCROLL_CONTROLLER -- requirements
Module: scroll_controller

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2: number of compositor layers sequenced.
REQ-002 SHALL have parameter OFFSET_W, default 12: signed offset/velocity width.
REQ-003 SHALL have parameter MIN_OFF, default -600: lower wrap bound, inclusive.
REQ-004 SHALL have parameter MAX_OFF, default 600: upper wrap bound, inclusive.
REQ-005 SHALL have ports:
- clk  in  1  single clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- vsync  in  1  VGA vsync, active-low pulse, same clock domain.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_layer  in  $clog2(NUM_LAYERS)  target layer.
- cmd_field  in  3  0=HVEL, 1=VVEL, 2=HPOS, 3=VPOS, 4=ENABLE, 5-7 reserved.
- cmd_data  in  OFFSET_W  signed payload.
- hoffset  out  NUM_LAYERS*OFFSET_W  packed per-layer horizontal offsets; layer i at [i*OFFSET_W +: OFFSET_W].
- voffset  out  NUM_LAYERS*OFFSET_W  packed per-layer vertical offsets; same packing.
- frame_done  out  1  one-cycle pulse when new offsets are published.
- frame_count  out  16  published-frame counter.

Function
REQ-006 SHALL detect a frame tick in cycle T when vsync is 0 and the registered vsync is 1 (falling edge).
REQ-007 SHALL implement FSM states IDLE, UPDATE and COMMIT:
- IDLE -> UPDATE on a tick.
- UPDATE lasts exactly NUM_LAYERS cycles, processing layer i in cycle T+1+i.
- UPDATE -> COMMIT.
- COMMIT -> IDLE after one cycle.
REQ-008 SHALL drive cmd_ready=1 only in IDLE; a command transfers when cmd_valid && cmd_ready.
REQ-009 SHALL write each accepted command into per-layer shadow registers:
- HVEL/VVEL: velocity.
- HPOS/VPOS: pending position plus a set pending-load flag.
- ENABLE: cmd_data[0].
- Reserved fields: accepted and ignored.
REQ-010 SHALL include in the current frame's update a command accepted in the same cycle as a tick.
REQ-011 SHALL compute per axis in UPDATE, into working registers:
- If the load flag is set: new = pending position, then clear the flag.
- Else if enabled: new = off + vel, evaluated in OFFSET_W+1 signed bits.
- Else: new = off.
REQ-012 SHALL wrap a stepped result: new < MIN_OFF gives MAX_OFF; new > MAX_OFF gives MIN_OFF; otherwise new. Loaded values are not wrapped.
REQ-013 SHALL apply position loads regardless of ENABLE.
REQ-014 SHALL, at the clock edge ending COMMIT (cycle T+1+NUM_LAYERS):
- copy all working offsets to hoffset/voffset simultaneously;
- increment frame_count, wrapping 0xFFFF to 0;
- assert frame_done for exactly the following cycle.
REQ-015 SHALL change hoffset/voffset only at the COMMIT edge; the outputs SHALL never show a partial-frame update.
REQ-016 SHALL ignore ticks that occur outside IDLE.
REQ-017 SHALL let the last write win when one field of one layer is written multiple times before a tick.

Reset
REQ-018 SHALL, on rst_n=0 and regardless of clk, asynchronously clear:
- all offsets, working registers, velocities, pending positions, load flags and enables to 0;
- frame_count and frame_done to 0;
- FSM to IDLE;
- the registered vsync to 1.
REQ-019 SHALL drive cmd_ready=1 one cycle after rst_n deasserts.
REQ-020 SHALL abandon any UPDATE or COMMIT in progress when reset asserts, leaving the outputs at 0 and no frame_done pulse.

Verification
REQ-021 Bench SHALL cover reset: assert rst_n=0 mid-frame -> hoffset=voffset=0, frame_count=0, frame_done=0, cmd_ready=1 after release.
REQ-022 Bench SHALL cover step: layer1 HPOS=600, HVEL=-1, ENABLE=1, then ticks 1, 2 and 3 -> hoffset layer1 = 600, 599, 598; layer0 stays 0; frame_count = 1, 2, 3.
REQ-023 Bench SHALL cover wrap: layer0 HPOS=-600, HVEL=-1, ENABLE=1; then tick, tick -> -600, then 600. Also VPOS=598, VVEL=+5 -> 598, then -600.
REQ-024 Bench SHALL cover the handshake: hold cmd_valid through a tick at T -> cmd_ready=0 in cycles T+1..T+1+NUM_LAYERS, the command is accepted at T+2+NUM_LAYERS, and frame_done=1 at T+2+NUM_LAYERS.
REQ-025 Bench SHALL cover tick/command coincidence: HPOS=100 accepted in the tick cycle -> published offset 100 at that frame's commit.
REQ-026 Bench SHALL cover reset mid-UPDATE: rst_n=0 at T+1 -> no frame_done pulse, outputs 0, and a following tick processes from cleared state.
